// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: round-robin owner of a shared memory port for cache line refills.
// The winning requester holds the port for a whole line of BEATS words. Word addresses
// are sequenced inside the line, and each returned beat is steered to the owner.
module mem_refill_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned BEATS      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [WORD_WIDTH-1:0]         rsp_data_o,
  output logic [$clog2(BEATS)-1:0]      rsp_beat_o,
  output logic                          rsp_last_o,
  output logic                          mem_req_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  input  logic                          mem_valid_i,
  input  logic [WORD_WIDTH-1:0]         mem_data_i
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned OFF_W  = BEAT_W + 2;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        owner;
  logic [BEAT_W-1:0]       beat_cnt;
  logic [ADDR_WIDTH-1:0]   line_addr;

  logic                    arb_found;
  logic [IDX_W-1:0]        arb_idx;
  int unsigned             arb_cand;
  logic [ADDR_WIDTH-1:0]   arb_addr;

  // Round-robin pick: first pending request scanning upward from rr_ptr.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      arb_cand = (32'(rr_ptr) + i) % NUM_REQ;
      if (!arb_found && req_i[IDX_W'(arb_cand)]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(arb_cand);
      end
    end
  end

  assign arb_addr = addr_i[32'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];

  // Refill FSM: latch owner and line base, count beats, advance the pointer after a line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      line_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            owner     <= arb_idx;
            line_addr <= arb_addr & LINE_MASK;
            beat_cnt  <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_valid_i) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (beat_cnt == LAST_BEAT) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          rr_ptr <= (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port drive decoded from the registered state; response path follows mem_valid_i directly.
  always_comb begin
    gnt_o       = '0;
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    rsp_beat_o  = '0;
    rsp_last_o  = 1'b0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    if (state == BUSY) begin
      gnt_o[owner] = 1'b1;
      mem_req_o    = 1'b1;
      mem_addr_o   = line_addr | (ADDR_WIDTH'(beat_cnt) << 2);
      if (mem_valid_i) begin
        rsp_valid_o[owner] = 1'b1;
        rsp_data_o         = mem_data_i;
        rsp_beat_o         = beat_cnt;
        rsp_last_o         = (beat_cnt == LAST_BEAT);
      end
    end
  end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Bench for mem_refill_arbiter with three requesters and 4-beat lines.
module tb_mem_refill_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned WW = 32;
  localparam int unsigned BT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*AW-1:0]  addr;
  logic [NR-1:0]     gnt_o;
  logic [NR-1:0]     rsp_valid_o;
  logic [WW-1:0]     rsp_data_o;
  logic [1:0]        rsp_beat_o;
  logic              rsp_last_o;
  logic              mem_req_o;
  logic [AW-1:0]     mem_addr_o;
  logic              mem_valid;
  logic [WW-1:0]     mem_data;
  logic [73:0]       all_out;

  typedef struct {
    int unsigned owner;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  beat;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          errors  = 0;
  int unsigned rr_model = 0;

  mem_refill_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BEATS(BT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_i(req),
    .addr_i(addr),
    .gnt_o(gnt_o),
    .rsp_valid_o(rsp_valid_o),
    .rsp_data_o(rsp_data_o),
    .rsp_beat_o(rsp_beat_o),
    .rsp_last_o(rsp_last_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_valid_i(mem_valid),
    .mem_data_i(mem_data)
  );

  always #5 clk = ~clk;

  assign all_out = {gnt_o, rsp_valid_o, rsp_data_o, rsp_beat_o, rsp_last_o, mem_req_o, mem_addr_o};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors so far", vectors);
    $fatal(1, "watchdog");
  end

  // Memory contents model: a fixed scramble of the word address.
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference round-robin choice.
  function automatic int unsigned pick(input logic [NR-1:0] r, input int unsigned rr);
    int unsigned c;
    for (int unsigned i = 0; i < NR; i++) begin
      c = (rr + i) % NR;
      if (r[2'(c)]) return c;
    end
    return 0;
  endfunction

  task automatic set_addr(input int unsigned r, input logic [31:0] a);
    addr[r*AW +: AW] = a;
  endtask

  // Queue the four beats a refill of line a for requester r must produce.
  task automatic push_line(input int unsigned r, input logic [31:0] a);
    logic [31:0] base;
    logic [31:0] wa;
    exp_t e;
    base = {a[31:4], 4'h0};
    for (int b = 0; b < 4; b++) begin
      wa      = base + 32'(b * 4);
      e.owner = r;
      e.addr  = wa;
      e.data  = data_of(wa);
      e.beat  = 2'(b);
      e.last  = (b == 3);
      sb.push_back(e);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      mem_valid = 1'b0;
      #1;
    end
  endtask

  // Wait (bounded) for mem_req_o; check owner and number of low cycles first seen.
  task automatic wait_grant(input int unsigned exp_owner, input int exp_gap);
    int low;
    bit seen;
    low  = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      mem_valid = 1'b0;
      #1;
      if (mem_req_o === 1'b1) seen = 1'b1;
      else low++;
    end
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL grant_timeout: mem_req_o stayed low, wanted owner %0d", exp_owner);
    end else begin
      vectors++;
      if (gnt_o !== 3'(1 << exp_owner)) begin
        errors++;
        $display("FAIL grant_owner: gnt_o=%b, wanted %b", gnt_o, 3'(1 << exp_owner));
      end
      if (low != exp_gap) begin
        errors++;
        $display("FAIL req_gap: mem_req_o low for %0d cycles, wanted %0d", low, exp_gap);
      end
    end
    rr_model = (exp_owner + 1) % NR;
  endtask

  // Feed one line from the memory model, comparing each response against the scoreboard.
  task automatic serve_line(input int gapmax, input int drop_after, input int unsigned drop_bit);
    exp_t e;
    int   gap;
    for (int b = 0; b < 4; b++) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL scoreboard_empty: no expected beat for beat %0d", b);
        return;
      end
      e = sb.pop_front();
      if (b > 0) idle_cycles(1);
      gap = int'($urandom_range(gapmax, 0));
      for (int g = 0; g < gap; g++) begin
        vectors++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== e.addr || rsp_valid_o !== 3'b000) begin
          errors++;
          $display("FAIL stall_hold: req=%b addr=%h rsp_valid=%b, wanted req=1 addr=%h rsp_valid=000",
                   mem_req_o, mem_addr_o, rsp_valid_o, e.addr);
        end
        idle_cycles(1);
      end
      mem_valid = 1'b1;
      mem_data  = data_of(mem_addr_o);
      #1;
      vectors++;
      if (mem_addr_o !== e.addr) begin
        errors++;
        $display("FAIL beat_addr: mem_addr_o=%h, wanted %h (beat %0d)", mem_addr_o, e.addr, e.beat);
      end
      vectors++;
      if (rsp_valid_o !== 3'(1 << e.owner) || rsp_data_o !== e.data || rsp_beat_o !== e.beat ||
          rsp_last_o !== e.last || gnt_o !== 3'(1 << e.owner)) begin
        errors++;
        $display("FAIL beat_resp: valid=%b data=%h beat=%0d last=%b gnt=%b, wanted valid=%b data=%h beat=%0d last=%b",
                 rsp_valid_o, rsp_data_o, rsp_beat_o, rsp_last_o, gnt_o,
                 3'(1 << e.owner), e.data, e.beat, e.last);
      end
      if (b == drop_after) req[2'(drop_bit)] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = '0;
    addr      = '0;
    mem_valid = 1'b1;
    mem_data  = 32'hFFFF_FFFF;
    idle_cycles(2);
    vectors++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: outputs=%h, wanted all zero", all_out);
    end
    @(negedge clk);
    mem_valid = 1'b0;
    rst_n     = 1'b1;
    rr_model  = 0;
  endtask

  task automatic test_single();
    set_addr(0, 32'h0000_1234);
    req = 3'b001;
    push_line(0, 32'h0000_1234);
    wait_grant(0, 0);
    serve_line(0, 3, 0);
    @(negedge clk);
    mem_valid = 1'b1;
    #1;
    vectors++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL done_quiet: outputs=%h in DONE, wanted all zero", all_out);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL idle_quiet: outputs=%h in IDLE with mem_valid, wanted all zero", all_out);
    end
    mem_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int unsigned o;
    int unsigned prev;
    set_addr(0, 32'h0000_8F7C);
    set_addr(1, 32'h4000_0040);
    req  = 3'b011;
    prev = NR;
    for (int k = 0; k < 4; k++) begin
      o = pick(req, rr_model);
      vectors++;
      if (o == prev) begin
        errors++;
        $display("FAIL alternation: refill %0d again chose requester %0d", k, o);
      end
      prev = o;
      push_line(o, (o == 0) ? 32'h0000_8F7C : 32'h4000_0040);
      wait_grant(o, (k == 0) ? 0 : 2);
      serve_line(0, -1, 0);
    end
    req = '0;
    idle_cycles(2);
  endtask

  task automatic test_stall();
    set_addr(2, 32'hDEAD_BEEF);
    req = 3'b100;
    push_line(2, 32'hDEAD_BEEF);
    wait_grant(2, 0);
    set_addr(0, 32'h1111_1110);
    set_addr(1, 32'h2222_2220);
    set_addr(2, 32'h0BAD_F00D);
    req = 3'b111;
    serve_line(5, 3, 0);
    req = '0;
    idle_cycles(2);
  endtask

  task automatic test_spurious();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_valid = 1'b1;
      mem_data  = $urandom;
      #1;
      vectors++;
      if (all_out !== '0) begin
        errors++;
        $display("FAIL spurious_idle: outputs=%h with mem_valid in IDLE, wanted all zero", all_out);
      end
    end
    set_addr(0, 32'h0000_0FF8);
    req = 3'b001;
    push_line(0, 32'h0000_0FF8);
    wait_grant(0, 0);
    serve_line(2, 1, 0);
    idle_cycles(1);
    vectors++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL abort_done: outputs=%h after dropped-request line, wanted all zero", all_out);
    end
    idle_cycles(2);
    vectors++;
    if (mem_req_o !== 1'b0 || gnt_o !== 3'b000) begin
      errors++;
      $display("FAIL no_regrant: mem_req=%b gnt=%b with no request, wanted 0 and 000", mem_req_o, gnt_o);
    end
  endtask

  task automatic test_fairness();
    set_addr(0, 32'h0000_2000);
    set_addr(1, 32'h0000_4004);
    set_addr(2, 32'h0000_6008);
    req = 3'b001;
    push_line(0, 32'h0000_2000);
    wait_grant(0, 0);
    serve_line(0, -1, 0);
    req = 3'b101;
    push_line(2, 32'h0000_6008);
    wait_grant(2, 2);
    serve_line(0, -1, 0);
    req = 3'b011;
    push_line(0, 32'h0000_2000);
    wait_grant(0, 2);
    serve_line(0, -1, 0);
    req = '0;
    idle_cycles(2);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    set_addr(0, 32'h0000_3000);
    set_addr(2, 32'h0000_5000);
    req = 3'b101;
    push_line(pick(req, rr_model), 32'h0000_5000);
    wait_grant(2, 0);
    e         = sb.pop_front();
    mem_valid = 1'b1;
    mem_data  = data_of(mem_addr_o);
    #1;
    vectors++;
    if (rsp_valid_o !== 3'b100 || rsp_data_o !== e.data || rsp_beat_o !== 2'd0) begin
      errors++;
      $display("FAIL pre_reset_beat: valid=%b data=%h beat=%0d, wanted 100 %h 0",
               rsp_valid_o, rsp_data_o, rsp_beat_o, e.data);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL async_reset: outputs=%h right after rst_n fell mid-refill, wanted all zero", all_out);
    end
    sb.delete();
    idle_cycles(1);
    rst_n     = 1'b1;
    rr_model  = 0;
    push_line(pick(req, rr_model), 32'h0000_3000);
    wait_grant(0, 0);
    serve_line(1, 3, 0);
    req = '0;
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_spurious();
    test_fairness();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d expected beats never delivered, wanted 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
